stk_cmd_arb: RTL and testbench

// - Round-robin arbiter sharing the single stk pipeline command port between ENGS_N engine command interfaces.
// - Sits between the per-engine command interfaces and the stk pipeline.
// - Holds off grants while the pipeline initialises, and masks PUSH while the stack is full.
// - Issues one registered command per cycle to the pipeline over a vld/rdy handshake.
//

---
 rtl/stk_cmd_arb.sv | 192 +++++++++++++++++++
 tb/tb_stk_cmd_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stk_cmd_arb.sv
// ---------------------------------------------------------------------------
// stk_cmd_arb
//
// Round-robin arbiter that shares the single stk pipeline command port
// between ENGS_N engine command interfaces. Grants are held off while the
// pipeline allocator initialises. PUSH requests are masked while the stack
// is full. At most one command per cycle is registered towards the pipeline
// over a vld/rdy handshake.
//
// Ports
//   clk            clock, all state on posedge
//   arst           asynchronous reset, active-high
//   i_cmd_vld      per-engine request, held until acked
//   i_cmd_opcode   per-engine opcode, packed ENGS_N x OP_W
//   i_cmd_dat      per-engine data, packed ENGS_N x DAT_W
//   o_cmd_ack      one-hot grant pulse, request consumed this cycle
//   i_init_busy    pipeline allocator initialising
//   i_full         no free stack slots
//   o_pipe_vld     registered command valid
//   o_pipe_engid   granted engine index
//   o_pipe_opcode  registered opcode
//   o_pipe_dat     registered data
//   i_pipe_rdy     pipeline accepts o_pipe_* this cycle
//   o_grant_cnt    per-engine grant counters, packed ENGS_N x CNT_W
//
// Optional feature macro: STK_CMD_ARB_PERF_EN
//   Defined   : o_grant_cnt holds saturating per-engine grant counters.
//   Undefined : o_grant_cnt is tied to zero and no counter flops exist.
//
// OP_W and OP_PUSH mirror stk_pkg::opcode_t and stk_pkg::OP_PUSH, so that
// this file stays self-contained.
// ---------------------------------------------------------------------------
module stk_cmd_arb #(
    parameter int              ENGS_N  = 4,
    parameter int              DAT_W   = 128,
    parameter int              CNT_W   = 32,
    parameter int              OP_W    = 2,
    parameter logic [OP_W-1:0] OP_PUSH = OP_W'(1)
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [ENGS_N-1:0]          i_cmd_vld,
    input  logic [ENGS_N*OP_W-1:0]     i_cmd_opcode,
    input  logic [ENGS_N*DAT_W-1:0]    i_cmd_dat,
    output logic [ENGS_N-1:0]          o_cmd_ack,
    input  logic                       i_init_busy,
    input  logic                       i_full,
    output logic                       o_pipe_vld,
    output logic [$clog2(ENGS_N)-1:0]  o_pipe_engid,
    output logic [OP_W-1:0]            o_pipe_opcode,
    output logic [DAT_W-1:0]           o_pipe_dat,
    input  logic                       i_pipe_rdy,
    output logic [ENGS_N*CNT_W-1:0]    o_grant_cnt
);

    localparam int ID_W = $clog2(ENGS_N);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              vld_q, vld_d;
    logic [ID_W-1:0]   engid_q, engid_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [DAT_W-1:0]  dat_q, dat_d;

    logic [ENGS_N-1:0] elig;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic              ld;

    // An engine may compete when it requests, unless it wants to PUSH onto a
    // full stack.
    always_comb begin
        elig = '0;
        for (int i = 0; i < ENGS_N; i++) begin
            elig[i] = i_cmd_vld[i] &
                      ~(i_full & (i_cmd_opcode[i*OP_W +: OP_W] == OP_PUSH));
        end
    end

    // Rotating-priority search starting at ptr_q. ENGS_N is a power of two,
    // so the ID_W-bit sum wraps modulo ENGS_N by itself.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < ENGS_N; k++) begin
            if (!found && elig[ptr_q + ID_W'(k)]) begin
                found  = 1'b1;
                winner = ptr_q + ID_W'(k);
            end
        end
    end

    // A grant fires only in RUN, when the output slot is empty or being
    // drained this cycle, and when some engine is eligible.
    always_comb begin
        ld        = (state_q == ST_RUN) & (~vld_q | i_pipe_rdy) & found;
        o_cmd_ack = '0;
        if (ld) begin
            o_cmd_ack[winner] = 1'b1;
        end
    end

    // INIT waits for the allocator to finish. RUN falls back to INIT whenever
    // the allocator becomes busy again. The output slot is untouched by this.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (!i_init_busy) state_d = ST_RUN;
            ST_RUN:  if (i_init_busy)  state_d = ST_INIT;
            default: state_d = ST_INIT;
        endcase
    end

    // Output slot and pointer. A grant overwrites the slot even if it is being
    // consumed in the same cycle, so back-to-back commands have no bubble.
    always_comb begin
        ptr_d    = ptr_q;
        vld_d    = vld_q;
        engid_d  = engid_q;
        opcode_d = opcode_q;
        dat_d    = dat_q;
        if (ld) begin
            ptr_d    = winner + ID_W'(1);
            vld_d    = 1'b1;
            engid_d  = winner;
            opcode_d = i_cmd_opcode[int'(winner)*OP_W +: OP_W];
            dat_d    = i_cmd_dat[int'(winner)*DAT_W +: DAT_W];
        end else if (i_pipe_rdy && vld_q) begin
            vld_d = 1'b0;
        end
    end

    // State registers. Reset drops any held command.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            vld_q    <= 1'b0;
            engid_q  <= '0;
            opcode_q <= '0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            vld_q    <= vld_d;
            engid_q  <= engid_d;
            opcode_q <= opcode_d;
            dat_q    <= dat_d;
        end
    end

    assign o_pipe_vld    = vld_q;
    assign o_pipe_engid  = engid_q;
    assign o_pipe_opcode = opcode_q;
    assign o_pipe_dat    = dat_q;

`ifdef STK_CMD_ARB_PERF_EN
    logic [CNT_W-1:0] cnt_q [ENGS_N];

    // Per-engine grant counters. They saturate at all-ones and are cleared
    // only by reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < ENGS_N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENGS_N; i++) begin
                if (o_cmd_ack[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Flatten the counter array onto the packed port.
    always_comb begin
        o_grant_cnt = '0;
        for (int i = 0; i < ENGS_N; i++) begin
            o_grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`else
    assign o_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_stk_cmd_arb.sv
// ---------------------------------------------------------------------------
// tb_stk_cmd_arb
//
// Self-checking bench for stk_cmd_arb with ENGS_N=4, DAT_W=128, CNT_W=32.
// A cycle-level behavioural model of the arbitration rules is checked against
// the DUT on every negedge. The directed scenarios also pin literal ack
// sequences and payloads.
// Honours STK_CMD_ARB_PERF_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_stk_cmd_arb;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int CW = 32;
    localparam int OW = 2;
    localparam logic [OW-1:0] OPC_PUSH = 2'd1;
    localparam logic [OW-1:0] OPC_POP  = 2'd2;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic [N-1:0]      cmdVld = '0;
    logic [N*OW-1:0]   opc = '0;
    logic [N*DW-1:0]   datBus = '0;
    logic [N-1:0]      cmdAck;
    logic              initBusy = 1'b1;
    logic              full = 1'b0;
    logic              pipeVld;
    logic [1:0]        pipeEngid;
    logic [OW-1:0]     pipeOpcode;
    logic [DW-1:0]     pipeDat;
    logic              pipeRdy = 1'b0;
    logic [N*CW-1:0]   grantCnt;

    int total = 0;
    int bad   = 0;

    stk_cmd_arb #(
        .ENGS_N (N),
        .DAT_W  (DW),
        .CNT_W  (CW),
        .OP_W   (OW),
        .OP_PUSH(OPC_PUSH)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .i_cmd_vld    (cmdVld),
        .i_cmd_opcode (opc),
        .i_cmd_dat    (datBus),
        .o_cmd_ack    (cmdAck),
        .i_init_busy  (initBusy),
        .i_full       (full),
        .o_pipe_vld   (pipeVld),
        .o_pipe_engid (pipeEngid),
        .o_pipe_opcode(pipeOpcode),
        .o_pipe_dat   (pipeDat),
        .i_pipe_rdy   (pipeRdy),
        .o_grant_cnt  (grantCnt)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Single comparison point: it counts the comparison and reports a mismatch.
    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // A recognisable payload per engine and sequence number.
    function automatic logic [DW-1:0] mkDat(input int e, input int s);
        return {32'hE000_0000 + 32'(e), 32'(s), 32'hA5A5_0000 | 32'(e), 32'(s * 7 + e)};
    endfunction

    // Present command fields for one engine.
    task automatic setCmd(input int e, input logic [OW-1:0] op, input int s);
        opc[e*OW +: OW]    = op;
        datBus[e*DW +: DW] = mkDat(e, s);
    endtask

    // Advance one clock edge, then drive the request and control inputs and let
    // the combinational ack settle.
    task automatic applyStimulus(input logic [N-1:0] v, input bit rdy,
                                 input bit busy, input bit fl);
        @(posedge clk);
        #1;
        cmdVld   = v;
        pipeRdy  = rdy;
        initBusy = busy;
        full     = fl;
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Model state: the arbiter is in RUN exactly when init_busy was low at the
    // previous edge. The output slot is a single entry, and the pointer is the
    // next engine to favour.
    bit              mRun = 1'b0;
    int              mPtr = 0;
    bit              mVld = 1'b0;
    int              mEng = 0;
    logic [OW-1:0]   mOp  = '0;
    logic [DW-1:0]   mDat = '0;
    logic [CW-1:0]   mCnt [N];

    function automatic bit isEligible(input int e);
        return cmdVld[e] && !(full && (opc[e*OW +: OW] == OPC_PUSH));
    endfunction

    always @(negedge clk) begin : modelCmp
        int w;
        logic [N-1:0]  expAck;
        logic [CW-1:0] expCnt;
        if (arst) begin
            mRun = 1'b0; mPtr = 0; mVld = 1'b0; mEng = 0; mOp = '0; mDat = '0;
            for (int e = 0; e < N; e++) mCnt[e] = '0;
        end
        w = -1;
        if (!arst && mRun && (!mVld || pipeRdy)) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && isEligible((mPtr + k) % N)) w = (mPtr + k) % N;
            end
        end
        expAck = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        checkOutput("mdl_ack",    DW'(cmdAck),     DW'(expAck));
        checkOutput("mdl_vld",    DW'(pipeVld),    DW'(mVld));
        checkOutput("mdl_engid",  DW'(pipeEngid),  DW'(mEng));
        checkOutput("mdl_opcode", DW'(pipeOpcode), DW'(mOp));
        checkOutput("mdl_dat",    pipeDat,         mDat);
        for (int e = 0; e < N; e++) begin
`ifdef STK_CMD_ARB_PERF_EN
            expCnt = mCnt[e];
`else
            expCnt = '0;
`endif
            checkOutput("mdl_cnt", DW'(grantCnt[e*CW +: CW]), DW'(expCnt));
        end
        if (!arst) begin
            if (w >= 0) begin
                mVld = 1'b1;
                mEng = w;
                mOp  = opc[w*OW +: OW];
                mDat = datBus[w*DW +: DW];
                mPtr = (w + 1) % N;
                if (mCnt[w] != '1) mCnt[w] = mCnt[w] + 1'b1;
            end else if (pipeRdy && mVld) begin
                mVld = 1'b0;
            end
            mRun = !initBusy;
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin : stim
        logic [N-1:0] lastAck;
        logic [N-1:0] nv;
        logic [N-1:0] newCmd;

        for (int e = 0; e < N; e++) setCmd(e, OPC_POP, 0);

        // Reset held, allocator busy, every engine requesting.
        applyStimulus(4'hF, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'hF, 1'b1, 1'b1, 1'b0);
        checkOutput("rst_vld", DW'(pipeVld), DW'(0));
        checkOutput("rst_ack", DW'(cmdAck), DW'(0));
        checkOutput("rst_dat", pipeDat, '0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        #1;

        // INIT: no grants while busy, and none in the cycle busy first reads low.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(4'hF, 1'b1, 1'b1, 1'b0);
            checkOutput("init_noack", DW'(cmdAck), DW'(0));
        end
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        checkOutput("busy_fall_noack", DW'(cmdAck), DW'(0));
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        checkOutput("first_ack_eng0", DW'(cmdAck), DW'(4'b0001));

        // All engines requesting, pipeline always ready: strict rotation.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
            checkOutput("rr_ack", DW'(cmdAck), DW'(4'b0001 << ((k + 1) % N)));
            checkOutput("rr_vld", DW'(pipeVld), DW'(1));
            checkOutput("rr_engid", DW'(pipeEngid), DW'(k % N));
        end

        // Drain, then eng2 alone with the pipeline stalled.
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain_engid", DW'(pipeEngid), DW'(0));
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        checkOutput("stall_vld_empty", DW'(pipeVld), DW'(0));
        checkOutput("stall_ack_eng2", DW'(cmdAck), DW'(4'b0100));
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
            if (c == 0) setCmd(2, OPC_POP, 1);
            checkOutput("stall_noack", DW'(cmdAck), DW'(0));
            checkOutput("stall_vld", DW'(pipeVld), DW'(1));
            checkOutput("stall_dat", pipeDat, mkDat(2, 0));
        end
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        checkOutput("replace_ack", DW'(cmdAck), DW'(4'b0100));
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("replace_dat", pipeDat, mkDat(2, 1));
        checkOutput("replace_vld", DW'(pipeVld), DW'(1));

        // Full stack: eng0 PUSH masked, eng1 POP proceeds (pointer now at 3).
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b1);
        setCmd(0, OPC_PUSH, 2);
        setCmd(1, OPC_POP, 2);
        applyStimulus(4'b0011, 1'b1, 1'b0, 1'b1);
        checkOutput("full_ack_eng1", DW'(cmdAck), DW'(4'b0010));
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1);
        checkOutput("full_push_masked", DW'(cmdAck), DW'(0));
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        checkOutput("unfull_ack_eng0", DW'(cmdAck), DW'(4'b0001));

        // Busy pulse in RUN with a held entry and the pipeline stalled.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0);
            checkOutput("busy_noack", DW'(cmdAck), DW'(0));
            checkOutput("busy_hold_vld", DW'(pipeVld), DW'(1));
            checkOutput("busy_hold_op", DW'(pipeOpcode), DW'(OPC_PUSH));
        end
        applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0);
        checkOutput("busy_deliver_vld", DW'(pipeVld), DW'(1));
        checkOutput("busy_deliver_ack", DW'(cmdAck), DW'(0));
        applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0);
        checkOutput("busy_drained", DW'(pipeVld), DW'(0));
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        checkOutput("busy_fall_noack2", DW'(cmdAck), DW'(0));
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        checkOutput("busy_resume_eng1", DW'(cmdAck), DW'(4'b0010));

        // Reset mid-operation drops the held command.
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_rst_ack", DW'(cmdAck), DW'(4'b0100));
        @(posedge clk);
        #1;
        arst = 1'b1;
        #1;
        checkOutput("midrst_vld", DW'(pipeVld), DW'(0));
        checkOutput("midrst_ack", DW'(cmdAck), DW'(0));
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        #1;
        checkOutput("post_rst_noack", DW'(cmdAck), DW'(0));

        // 100 grants spread round-robin from eng0.
        for (int i = 0; i < 100; i++) begin
            applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
            checkOutput("perf_ack", DW'(cmdAck), DW'(4'b0001 << (i % N)));
        end
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
        for (int e = 0; e < N; e++) begin
`ifdef STK_CMD_ARB_PERF_EN
            checkOutput("perf_cnt25", DW'(grantCnt[e*CW +: CW]), DW'(25));
`else
            checkOutput("perf_cnt_tied0", DW'(grantCnt[e*CW +: CW]), DW'(0));
`endif
        end
        @(posedge clk);
        #1;
        arst = 1'b1;
        #1;
        checkOutput("perf_cnt_clear", DW'(grantCnt), DW'(0));
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        #1;

        // Mixed traffic: requests held until acked, random stalls, full, busy.
        lastAck = '0;
        for (int c = 0; c < 300; c++) begin
            newCmd = '0;
            for (int e = 0; e < N; e++) begin
                if (cmdVld[e] && !lastAck[e]) begin
                    nv[e] = 1'b1;
                end else begin
                    nv[e]     = ($urandom_range(0, 2) != 0);
                    newCmd[e] = nv[e];
                end
            end
            applyStimulus(nv, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 3) == 0);
            for (int e = 0; e < N; e++) begin
                if (newCmd[e]) setCmd(e, 2'($urandom_range(0, 3)), c + 10);
            end
            #1;
            lastAck = cmdAck;
        end

        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
